// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubble, branch flush, multi-cycle MDU hold with timeout.
// Latency: stall/flush outputs are combinational from inputs and FSM state; counters update on the clock edge.
// Backpressure: holds F/D/E while an MDU op is in EX; a timed-out MDU op is flushed from EX.
module pipeline_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32,
    parameter int MDU_MAX = 34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] RS1D,
    input  logic [REG_AW-1:0] RS2D,
    input  logic [REG_AW-1:0] RdE,
    input  logic              LoadE,
    input  logic              RegwriteE,
    input  logic              PCSrcE,
    input  logic              MduReqE,
    input  logic              MduDoneE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              MduStartE,
    output logic              MduErr,
    output logic [CNT_W-1:0]  StallCnt
);

    localparam int WW = $clog2(MDU_MAX + 1);

    typedef enum logic {IDLE, MDU_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic lu;
    logic stall_f, stall_d, stall_e, flush_d, flush_e, start;

    // Load-use hazard: a load in EX producing a register that DEC is about to read (x0 never hazards).
    assign lu = LoadE & RegwriteE & (RdE != '0) & ((RdE == RS1D) | (RdE == RS2D));

    // Next-state and stall/flush decode; MDU hold outranks MDU start, which outranks branch, then load-use.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MduReqE) begin
                    start   = 1'b1;
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    state_d = MDU_WAIT;
                    wait_d  = WW'(1);
                end else if (PCSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (MduDoneE) begin
                    // Result is valid: let the op retire out of EX on this edge.
                    state_d = IDLE;
                end else if (wait_q == WW'(MDU_MAX)) begin
                    // Unit never answered: kill the op in EX and record the error.
                    err_d   = 1'b1;
                    flush_e = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    wait_d  = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall-cycle counter saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_f && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    // State, wait counter, sticky error and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs forced quiet while reset is held so an asynchronous reset silences them immediately.
    always_comb begin
        StallF    = stall_f & ~rst;
        StallD    = stall_d & ~rst;
        StallE    = stall_e & ~rst;
        FlushD    = flush_d & ~rst;
        FlushE    = flush_e & ~rst;
        MduStartE = start   & ~rst;
    end

    assign MduErr   = err_q;
    assign StallCnt = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MDU_MAX=4.
// Inputs change at the falling edge; outputs are sampled 1ns later, well away from the rising edge.
// Expected values are hand-computed from the hazard rules.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  RS1D, RS2D, RdE;
    logic        LoadE, RegwriteE, PCSrcE, MduReqE, MduDoneE;
    logic        StallF, StallD, StallE, FlushD, FlushE, MduStartE, MduErr;
    logic [31:0] StallCnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .MDU_MAX(4)) dut (
        .clk(clk), .rst(rst), .RS1D(RS1D), .RS2D(RS2D), .RdE(RdE),
        .LoadE(LoadE), .RegwriteE(RegwriteE), .PCSrcE(PCSrcE),
        .MduReqE(MduReqE), .MduDoneE(MduDoneE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .MduStartE(MduStartE),
        .MduErr(MduErr), .StallCnt(StallCnt)
    );

    // Apply one cycle of inputs at the falling edge, then settle 1ns.
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic ld, input logic rw, input logic br,
                         input logic req, input logic done);
        @(negedge clk);
        RS1D = rs1; RS2D = rs2; RdE = rd; LoadE = ld; RegwriteE = rw;
        PCSrcE = br; MduReqE = req; MduDoneE = done;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        RS1D = 0; RS2D = 0; RdE = 0; LoadE = 0; RegwriteE = 0; PCSrcE = 0; MduReqE = 0; MduDoneE = 0;
        @(negedge clk); #1;
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE, MduStartE, MduErr} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b want=0000000", {StallF, StallD, StallE, FlushD, FlushE, MduStartE, MduErr});
        end
        n_cmp++;
        if (StallCnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", StallCnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use;
        // lw x5 in EX, DEC reads x5 as rs1
        drive(5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0);
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE} !== 5'b11001) begin
            n_bad++; $display("FAIL lu_rs1 got=%b want=11001", {StallF, StallD, StallE, FlushD, FlushE});
        end
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (StallCnt !== 32'd1 || StallF !== 1'b0) begin
            n_bad++; $display("FAIL lu_one_bubble cnt=%0d stallf=%b want cnt=1 stallf=0", StallCnt, StallF);
        end
        // match through rs2
        drive(5'd3, 5'd9, 5'd9, 1, 1, 0, 0, 0);
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE} !== 5'b11001) begin
            n_bad++; $display("FAIL lu_rs2 got=%b want=11001", {StallF, StallD, StallE, FlushD, FlushE});
        end
        // rd = x0 never hazards
        drive(5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE} !== 5'b0) begin
            n_bad++; $display("FAIL lu_x0 got=%b want=00000", {StallF, StallD, StallE, FlushD, FlushE});
        end
        // load that does not write rd
        drive(5'd7, 5'd0, 5'd7, 1, 0, 0, 0, 0);
        n_cmp++;
        if ({StallF, FlushE} !== 2'b00) begin
            n_bad++; $display("FAIL lu_norw got=%b want=00", {StallF, FlushE});
        end
        // non-load writer with matching rd
        drive(5'd7, 5'd0, 5'd7, 0, 1, 0, 0, 0);
        n_cmp++;
        if ({StallF, FlushE} !== 2'b00) begin
            n_bad++; $display("FAIL lu_noload got=%b want=00", {StallF, FlushE});
        end
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (StallCnt !== 32'd2) begin n_bad++; $display("FAIL lu_cnt got=%0d want=2", StallCnt); end
    endtask

    task automatic test_branch;
        drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE} !== 5'b00011) begin
            n_bad++; $display("FAIL branch got=%b want=00011", {StallF, StallD, StallE, FlushD, FlushE});
        end
        // branch beats a simultaneous load-use
        drive(5'd4, 5'd0, 5'd4, 1, 1, 1, 0, 0);
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE} !== 5'b00011) begin
            n_bad++; $display("FAIL branch_over_lu got=%b want=00011", {StallF, StallD, StallE, FlushD, FlushE});
        end
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1); // MduDoneE alone in IDLE is ignored
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE, MduStartE} !== 6'b0 || StallCnt !== 32'd2) begin
            n_bad++; $display("FAIL branch_clear_done_idle got=%b cnt=%0d want=000000 cnt=2",
                              {StallF, StallD, StallE, FlushD, FlushE, MduStartE}, StallCnt);
        end
    endtask

    task automatic test_mdu_done;
        logic [3:0] exp_start;
        logic [3:0] got_start;
        exp_start = 4'b1000;
        got_start = '0;
        for (int i = 0; i < 4; i++) begin
            drive(5'd0, 5'd0, 5'd3, 0, 1, 0, 1, 0);
            got_start[3-i] = MduStartE;
            n_cmp++;
            if ({StallF, StallD, StallE, FlushD, FlushE} !== 5'b11100) begin
                n_bad++; $display("FAIL mdu_hold cyc=%0d got=%b want=11100", i, {StallF, StallD, StallE, FlushD, FlushE});
            end
        end
        n_cmp++;
        if (got_start !== exp_start) begin n_bad++; $display("FAIL mdu_start_pulse got=%b want=%b", got_start, exp_start); end
        drive(5'd0, 5'd0, 5'd3, 0, 1, 0, 1, 1);
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE, MduStartE} !== 6'b0) begin
            n_bad++; $display("FAIL mdu_done_cycle got=%b want=000000", {StallF, StallD, StallE, FlushD, FlushE, MduStartE});
        end
        // back in IDLE: a load-use now produces its bubble
        drive(5'd6, 5'd0, 5'd6, 1, 1, 0, 0, 0);
        n_cmp++;
        if (StallCnt !== 32'd6 || {StallF, StallE, FlushE} !== 3'b101) begin
            n_bad++; $display("FAIL mdu_after cnt=%0d sfe=%b want cnt=6 sfe=101", StallCnt, {StallF, StallE, FlushE});
        end
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_mdu_timeout;
        // StallCnt is 7 here (6 + the load-use bubble above)
        for (int i = 0; i < 4; i++) begin
            drive(5'd0, 5'd0, 5'd8, 0, 1, 1'b0, 1, 0);
            n_cmp++;
            if ({StallF, StallD, StallE, FlushE, MduErr} !== 5'b11100) begin
                n_bad++; $display("FAIL to_hold cyc=%0d got=%b want=11100", i, {StallF, StallD, StallE, FlushE, MduErr});
            end
        end
        drive(5'd0, 5'd0, 5'd8, 0, 1, 0, 1, 0);
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE, MduStartE} !== 6'b000010) begin
            n_bad++; $display("FAIL to_flush got=%b want=000010", {StallF, StallD, StallE, FlushD, FlushE, MduStartE});
        end
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (MduErr !== 1'b1 || StallCnt !== 32'd11 || StallF !== 1'b0) begin
            n_bad++; $display("FAIL to_err err=%b cnt=%0d stallf=%b want err=1 cnt=11 stallf=0", MduErr, StallCnt, StallF);
        end
        drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (MduErr !== 1'b1) begin n_bad++; $display("FAIL to_sticky got=%b want=1", MduErr); end
    endtask

    task automatic test_reset_mid_mdu;
        drive(5'd0, 5'd0, 5'd2, 0, 1, 0, 1, 0); // start
        drive(5'd0, 5'd0, 5'd2, 0, 1, 0, 1, 0); // wait 1
        drive(5'd0, 5'd0, 5'd2, 0, 1, 0, 1, 0); // wait 2
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE, MduStartE, MduErr} !== 7'b0 || StallCnt !== 32'd0) begin
            n_bad++; $display("FAIL rst_mid got=%b cnt=%0d want=0000000 cnt=0",
                              {StallF, StallD, StallE, FlushD, FlushE, MduStartE, MduErr}, StallCnt);
        end
        @(negedge clk);
        rst = 1'b0;
        MduReqE = 1'b0;
        #1;
        n_cmp++;
        if ({StallF, StallE, MduStartE} !== 3'b000) begin
            n_bad++; $display("FAIL rst_idle got=%b want=000", {StallF, StallE, MduStartE});
        end
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_branch;
        test_mdu_done;
        test_mdu_timeout;
        test_reset_mid_mdu;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
